// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding byte/half/word access on a byte-enabled data bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of truncating them.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  output logic [3:0]        dbus_byteen,
  output logic              dbus_re,
  output logic              dbus_we,
  input  logic              dbus_waitrequest,
  input  logic [31:0]       dbus_rdata,
  input  logic              dbus_readdatavalid
);

  typedef enum logic [2:0] {StIdle, StReq, StWaitRd, StDone, StFault} state_e;

  state_e            state_q, state_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-3:0] word_addr_q, word_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        byteen_q, byteen_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept, illegal;
  logic [1:0]        req_off;
  logic [3:0]        req_byteen;
  logic [31:0]       req_lanes;
  logic [31:0]       shifted, load_ext;

  // Request decode: offset truncated to natural alignment, enables, lane replication, legality.
  always_comb begin
    accept = req_valid && (req_re || req_we);
    unique case (req_funct3[1:0])
      2'b00: begin
        req_off    = req_addr[1:0];
        req_byteen = 4'b0001 << req_off;
        req_lanes  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_off    = {req_addr[1], 1'b0};
        req_byteen = 4'b0011 << req_off;
        req_lanes  = {2{req_wdata[15:0]}};
      end
      default: begin
        req_off    = 2'b00;
        req_byteen = 4'b1111;
        req_lanes  = req_wdata;
      end
    endcase
    illegal = 1'b0;
    if (req_re && req_we) begin
      illegal = 1'b1;
    end else if (req_re) begin
      illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010 ||
                  req_funct3 == 3'b100 || req_funct3 == 3'b101);
    end else begin
      illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
      illegal = 1'b1;
    end
`endif
  end

  always_comb begin
    shifted = dbus_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      word_addr_q <= '0;
      wdata_q     <= 32'h0;
      byteen_q    <= 4'b0000;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
      byteen_q    <= byteen_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = illegal ? StFault : StReq;
      StReq:    if (!dbus_waitrequest) state_d = is_load_q ? StWaitRd : StDone;
      StWaitRd: if (dbus_readdatavalid) state_d = StDone;
      StDone:   state_d = StIdle;
      StFault:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    byteen_d    = byteen_q;
    rdata_d     = rdata_q;
    if (state_q == StIdle && accept) begin
      is_load_d   = req_re;
      funct3_d    = req_funct3;
      off_d       = req_off;
      word_addr_d = req_addr[ADDR_W-1:2];
      wdata_d     = req_lanes;
      byteen_d    = req_byteen;
      if (illegal) rdata_d = 32'h0;
    end else if (state_q == StWaitRd && dbus_readdatavalid) begin
      rdata_d = load_ext;
    end
  end

  // Output logic.
  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone) || (state_q == StFault);
    fault   = (state_q == StFault);
    dbus_re = (state_q == StReq) && is_load_q;
    dbus_we = (state_q == StReq) && !is_load_q;
  end

  assign rdata       = rdata_q;
  assign dbus_addr   = {word_addr_q, 2'b00};
  assign dbus_wdata  = wdata_q;
  assign dbus_byteen = byteen_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV32I core, driven by the decoder's `dbus_re`/`dbus_we` control bits. It takes one load or store per request, drives the data bus (word-addressed, byte-enabled, waitrequest/readdatavalid handshake), and returns a sign- or zero-extended load result with a one-cycle `done` pulse. Only one access is outstanding at a time; the core stalls on `busy`.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width on the core side and the bus side.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock; everything samples on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  access request from the core; sampled only in IDLE.
- `req_re`  in  1  load (from `dbus_re`).
- `req_we`  in  1  store (from `dbus_we`).
- `req_funct3`  in  3  access width and signedness, instruction bits [14:12].
- `req_addr`  in  ADDR_W  byte address (ALU result).
- `req_wdata`  in  32  store data (rs2).
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  valid with `done`; the access was illegal or misaligned.
- `rdata`  out  32  extended load result; holds until the next `done`.
- `dbus_addr`  out  ADDR_W  word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `dbus_wdata`  out  32  store data, lane-replicated.
- `dbus_byteen`  out  4  byte enables.
- `dbus_re`, `dbus_we`  out  1 each  bus read and write strobes.
- `dbus_waitrequest`  in  1  bus stall; the request is accepted in a cycle where this is low.
- `dbus_rdata`  in  32  read data.
- `dbus_readdatavalid`  in  1  read data valid.

## Operation
- States: IDLE, REQ, WAIT_RD, DONE, FAULT.
- **IDLE**: on `req_valid && (req_re || req_we)`, register funct3, address and data.
  - Illegal access goes to FAULT.
  - Otherwise go to REQ.
  - `req_valid` with neither `req_re` nor `req_we` is ignored.
- **Illegal access** is any of:
  - `req_re && req_we` both set;
  - load funct3 not in {000, 001, 010, 100, 101};
  - store funct3 not in {000, 001, 010};
  - misalignment, when enabled (see Configuration).
- **REQ**: drive `dbus_addr`, `dbus_byteen`, `dbus_wdata` and the strobe. Hold all bus outputs stable while `dbus_waitrequest` = 1. Once accepted:
  - a store goes to DONE;
  - a load goes to WAIT_RD.
- **WAIT_RD**: on `dbus_readdatavalid`, capture the extracted and extended data into `rdata`, then go to DONE. `dbus_re` is low in this state.
- **DONE**: `done` = 1 and `fault` = 0 for one cycle, then IDLE.
- **FAULT**: `done` = 1, `fault` = 1 and `rdata` = 0 for one cycle, then IDLE. No bus strobe is issued.
- **Byte enables**, with `o = addr[1:0]`:
  - byte: `4'b0001 << o`;
  - half: `4'b0011 << {o[1],1'b0}`;
  - word: `4'b1111`.
- **Store data lanes**: byte is `{4{wdata[7:0]}}`, half is `{2{wdata[15:0]}}`, word is `wdata`.
- **Load extraction**: `dbus_rdata >> (8*o)`, then:
  - LB/LH sign-extend from bit 7/15;
  - LBU/LHU zero-extend;
  - LW passes through.

## Timing
- Reset values:
  - `busy`, `done`, `fault`, `dbus_re`, `dbus_we` are 0;
  - `rdata`, `dbus_addr`, `dbus_wdata`, `dbus_byteen` are 0;
  - state is IDLE.
- Latency from the accept cycle T (no wait states):
  - strobe in T+1;
  - store `done` in T+2;
  - load: earliest `readdatavalid` in T+2, `done` in T+3;
  - fault `done` in T+1.
- `busy` rises in T+1 and falls in the same cycle `done` drops. A new request can be accepted in the cycle after `done`.
- Bus handshake:
  - `dbus_readdatavalid` is sampled only in WAIT_RD and ignored in every other state.
  - `dbus_waitrequest` is ignored outside REQ.
- Reset mid-access: at the next edge the state returns to IDLE and both strobes drop. A late `readdatavalid` after that is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - a half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, goes to FAULT;
  - no bus access is made.
- Undefined:
  - misaligned accesses proceed;
  - the offset used for enables and extraction is truncated to the natural alignment (half uses `{o[1],0}`, word uses 0);
  - `fault` is raised only for illegal funct3 or for `re` and `we` both set.

## Test plan
- **SW** to `0x100`, data `0xDEADBEEF`, waitrequest held 2 cycles:
  - bus shows addr `0x100`, byteen `1111`, data `0xDEADBEEF` stable for 3 cycles;
  - `done` in the cycle after acceptance;
  - `fault` = 0.
- **LB** from `0x203`, `dbus_rdata` = `0x80FF_0000`: `rdata` = `0xFFFF_FF80`. Same access as **LBU**: `0x0000_0080`.
- **SH** to `0x302`, data `0x1234_ABCD`: byteen `1100`, wdata `0xABCD_ABCD`.
- **LW** from `0x101**:
  - with the macro: `done` and `fault` in T+1, no strobe ever;
  - without the macro: bus addr `0x100`, `rdata` = the full word.
- **Illegal funct3** `011` load: fault pulse. **`re` and `we` both set**: fault pulse. Neither issues a bus strobe.
- **Reset mid-load** while in WAIT_RD:
  - all outputs return to 0 after one edge;
  - a `readdatavalid` in the following cycle produces no `done`.
